slide_window_nxn: RTL and testbench

- Parametrised successor to the fixed 5x5 sliding-window generator in the ISP pipeline.
- Generates a KSIZE x KSIZE window of DW-bit pixels over a raster stream using KSIZE-1 internal line buffers.
- Window is causal: its bottom-right element is the newest pixel.
- Adds selectable border handling (valid-only / zero-pad / replicate), explicit start-of-frame resync and per-frame latching of geometry; feeds demosaic, denoise and sharpen kernels.

---
 rtl/slide_window_nxn.sv | 225 ++++++++++++++++++++++
 tb/tb_slide_window_nxn.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slide_window_nxn.sv
// -----------------------------------------------------------------------------
// slide_window_nxn
// Generates a causal KSIZE x KSIZE window of DW-bit pixels over a raster
// stream.  KSIZE-1 chained line buffers supply the older rows; a KSIZE x KSIZE
// shift register holds the window.  Border handling is selected by BORDER:
//   0 = emit only fully populated windows (raw contents),
//   1 = emit every pixel, elements outside the frame read as zero,
//   2 = emit every pixel, elements outside the frame replicate the edge.
// Frame geometry is latched when pixel (0,0) is accepted; sof forces (0,0).
//
// Ports
//   isp_clk   clock
//   rst       synchronous reset, active high
//   dataIn    input pixel
//   dataEn    dataIn valid this cycle (gaps allowed)
//   sof       qualified by dataEn, marks pixel (0,0)
//   h_active  pixels per line
//   v_active  lines per frame
//   win_out   window, element (r,c) at [((r*KSIZE+c)+1)*DW-1 -: DW]
//   outEn     win_out valid for one cycle
//   endFlag   last pixel of the frame accepted
//   cur_x     column of the newest pixel in the presented window
//   cur_y     row of the newest pixel in the presented window
// -----------------------------------------------------------------------------
module slide_window_nxn #(
  parameter int DW     = 16,
  parameter int KSIZE  = 5,
  parameter int MAX_W  = 2048,
  parameter int CW     = 12,
  parameter int BORDER = 0
) (
  input  logic                      isp_clk,
  input  logic                      rst,
  input  logic [DW-1:0]             dataIn,
  input  logic                      dataEn,
  input  logic                      sof,
  input  logic [CW-1:0]             h_active,
  input  logic [CW-1:0]             v_active,
  output logic [DW*KSIZE*KSIZE-1:0] win_out,
  output logic                      outEn,
  output logic                      endFlag,
  output logic [CW-1:0]             cur_x,
  output logic [CW-1:0]             cur_y
);

  localparam int AW  = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int NLB = KSIZE - 1;
  localparam int WW  = DW * KSIZE * KSIZE;
  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam logic [CW-1:0] KM1_C = CW'(KSIZE - 1);

  // Index idx (row or column) holds a pixel inside the frame when the newest
  // pixel's coordinate pos reaches at least KSIZE-1-idx.
  function automatic logic is_real(input int idx, input logic [CW-1:0] pos);
    return (int'(pos) >= (KSIZE - 1 - idx));
  endfunction

  // Nearest in-frame index for replicate mode; in-frame indices pass through.
  function automatic int clamp_idx(input int idx, input logic [CW-1:0] pos);
    int first_real;
    first_real = KSIZE - 1 - int'(pos);
    if (idx >= first_real) begin
      return idx;
    end else begin
      return first_real;
    end
  endfunction

  logic [CW-1:0] h_cnt_r, v_cnt_r;
  logic [CW-1:0] h_act_r, v_act_r;
  logic [CW-1:0] x_s, y_s;
  logic [CW-1:0] h_eff_s, v_eff_s;
  logic [CW-1:0] h_nxt_s, v_nxt_s;
  logic          origin_s, last_col_s, last_row_s, out_valid_s;
  logic [AW-1:0] lb_addr_s;
  logic [WW-1:0] win_nxt_s;

  logic [DW-1:0] lb_mem_r [NLB][MAX_W];
  logic [DW-1:0] lb_rd_s  [NLB];
  logic [DW-1:0] sr_r     [KSIZE][KSIZE];
  logic [DW-1:0] sr_nxt_s [KSIZE][KSIZE];

  // Coordinate of the pixel offered this cycle; sof overrides the counters
  always_comb begin
    if (sof) begin
      x_s = {CW{1'b0}};
      y_s = {CW{1'b0}};
    end else begin
      x_s = h_cnt_r;
      y_s = v_cnt_r;
    end
  end

  // Effective geometry and next counter values; the origin pixel already
  // uses the geometry it is about to latch
  always_comb begin
    origin_s = (x_s == {CW{1'b0}}) && (y_s == {CW{1'b0}});
    if (origin_s) begin
      h_eff_s = h_active;
      v_eff_s = v_active;
    end else begin
      h_eff_s = h_act_r;
      v_eff_s = v_act_r;
    end
    last_col_s = (x_s == (h_eff_s - ONE_C));
    last_row_s = (y_s == (v_eff_s - ONE_C));
    if (last_col_s) begin
      h_nxt_s = {CW{1'b0}};
      if (last_row_s) begin
        v_nxt_s = {CW{1'b0}};
      end else begin
        v_nxt_s = y_s + ONE_C;
      end
    end else begin
      h_nxt_s = x_s + ONE_C;
      v_nxt_s = y_s;
    end
  end

  assign lb_addr_s = AW'(x_s);

  // Asynchronous read of every line buffer at the current column
  always_comb begin
    for (int k = 0; k < NLB; k++) begin
      lb_rd_s[k] = lb_mem_r[k][lb_addr_s];
    end
  end

  // Chained line buffers: read-before-write pushes each column one row deeper
  always_ff @(posedge isp_clk) begin
    if (dataEn && !rst) begin
      lb_mem_r[0][lb_addr_s] <= dataIn;
      for (int k = 1; k < NLB; k++) begin
        lb_mem_r[k][lb_addr_s] <= lb_rd_s[k-1];
      end
    end
  end

  // Next window contents: rows shift left, rightmost column takes new data
  always_comb begin
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE - 1; c++) begin
        sr_nxt_s[r][c] = sr_r[r][c+1];
      end
    end
    // Row r gets the pixel KSIZE-1-r rows above the newest one
    for (int r = 0; r < KSIZE - 1; r++) begin
      sr_nxt_s[r][KSIZE-1] = lb_rd_s[KSIZE-2-r];
    end
    sr_nxt_s[KSIZE-1][KSIZE-1] = dataIn;
  end

  // Border treatment of the next window; column masking also hides the
  // previous line's tail still sitting in the shift register
  always_comb begin
    win_nxt_s = {WW{1'b0}};
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        case (BORDER)
          32'sd1: begin
            if (is_real(r, y_s) && is_real(c, x_s)) begin
              win_nxt_s[(r*KSIZE+c)*DW +: DW] = sr_nxt_s[r][c];
            end else begin
              win_nxt_s[(r*KSIZE+c)*DW +: DW] = {DW{1'b0}};
            end
          end
          32'sd2: begin
            win_nxt_s[(r*KSIZE+c)*DW +: DW] =
              sr_nxt_s[clamp_idx(r, y_s)][clamp_idx(c, x_s)];
          end
          default: begin
            win_nxt_s[(r*KSIZE+c)*DW +: DW] = sr_nxt_s[r][c];
          end
        endcase
      end
    end
  end

  // Valid-only mode waits for a fully populated window
  always_comb begin
    if (BORDER == 0) begin
      out_valid_s = (x_s >= KM1_C) && (y_s >= KM1_C);
    end else begin
      out_valid_s = 1'b1;
    end
  end

  // Counters, geometry latch, window shift register and registered outputs
  always_ff @(posedge isp_clk) begin
    if (rst) begin
      h_cnt_r <= {CW{1'b0}};
      v_cnt_r <= {CW{1'b0}};
      h_act_r <= {CW{1'b0}};
      v_act_r <= {CW{1'b0}};
      win_out <= {WW{1'b0}};
      outEn   <= 1'b0;
      endFlag <= 1'b0;
      cur_x   <= {CW{1'b0}};
      cur_y   <= {CW{1'b0}};
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE; c++) begin
          sr_r[r][c] <= {DW{1'b0}};
        end
      end
    end else begin
      outEn   <= dataEn && out_valid_s;
      endFlag <= dataEn && last_col_s && last_row_s;
      if (dataEn) begin
        h_cnt_r <= h_nxt_s;
        v_cnt_r <= v_nxt_s;
        if (origin_s) begin
          h_act_r <= h_active;
          v_act_r <= v_active;
        end
        sr_r <= sr_nxt_s;
        if (out_valid_s) begin
          win_out <= win_nxt_s;
          cur_x   <= x_s;
          cur_y   <= y_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_slide_window_nxn.sv
// -----------------------------------------------------------------------------
// tb_slide_window_nxn
// Drives three instances (BORDER = 0, 1, 2) from one stimulus stream and
// checks them against a frame-array reference model: every accepted pixel is
// stored at its (x,y) and the expected window is read straight from the stored
// frame, with zero fill or clamping for out-of-frame coordinates.
// -----------------------------------------------------------------------------
module tb_slide_window_nxn;

  localparam int DW    = 16;
  localparam int K     = 5;
  localparam int MAX_W = 64;
  localparam int CW    = 12;
  localparam int WW    = DW * K * K;

  logic          isp_clk = 1'b0;
  logic          rst;
  logic [DW-1:0] dataIn;
  logic          dataEn;
  logic          sof;
  logic [CW-1:0] h_active;
  logic [CW-1:0] v_active;

  logic [WW-1:0] win  [3];
  logic          en   [3];
  logic          endf [3];
  logic [CW-1:0] cx   [3];
  logic [CW-1:0] cy   [3];

  always #5 isp_clk = ~isp_clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    slide_window_nxn #(
      .DW(DW), .KSIZE(K), .MAX_W(MAX_W), .CW(CW), .BORDER(g)
    ) u_dut (
      .isp_clk (isp_clk),
      .rst     (rst),
      .dataIn  (dataIn),
      .dataEn  (dataEn),
      .sof     (sof),
      .h_active(h_active),
      .v_active(v_active),
      .win_out (win[g]),
      .outEn   (en[g]),
      .endFlag (endf[g]),
      .cur_x   (cx[g]),
      .cur_y   (cy[g])
    );
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  int            mx, my, hact, vact;
  logic [DW-1:0] img [16][16];
  logic          exp_en  [3];
  logic          exp_end;
  logic [WW-1:0] exp_win [3];
  logic [CW-1:0] exp_cx  [3];
  logic [CW-1:0] exp_cy  [3];

  function automatic logic [DW-1:0] elem(input logic [WW-1:0] w, input int r, input int c);
    return w[(r*K+c)*DW +: DW];
  endfunction

  // Expected window for newest pixel (x,y) read from the stored frame
  function automatic logic [WW-1:0] model_win(input int m, input int x, input int y);
    logic [WW-1:0] w;
    int py, px;
    w = {WW{1'b0}};
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        py = y - (K - 1 - r);
        px = x - (K - 1 - c);
        if (m == 2) begin
          if (py < 0) py = 0;
          if (px < 0) px = 0;
          w[(r*K+c)*DW +: DW] = img[py][px];
        end else if (py >= 0 && px >= 0) begin
          w[(r*K+c)*DW +: DW] = img[py][px];
        end
      end
    end
    return w;
  endfunction

  // One clock: drive inputs, step the model for what the DUT sampled
  task automatic tick(input logic en_i, input logic [DW-1:0] d_i, input logic sof_i,
                      input logic rst_i);
    dataEn = en_i;
    dataIn = d_i;
    sof    = sof_i;
    rst    = rst_i;
    @(posedge isp_clk);
    #1;
    exp_end = 1'b0;
    for (int m = 0; m < 3; m++) exp_en[m] = 1'b0;
    if (rst_i) begin
      mx = 0;
      my = 0;
      for (int m = 0; m < 3; m++) begin
        exp_win[m] = {WW{1'b0}};
        exp_cx[m]  = {CW{1'b0}};
        exp_cy[m]  = {CW{1'b0}};
      end
    end else if (en_i) begin
      if (sof_i) begin
        mx = 0;
        my = 0;
      end
      if (mx == 0 && my == 0) begin
        hact = int'(h_active);
        vact = int'(v_active);
      end
      img[my][mx] = d_i;
      exp_end = (mx == hact - 1) && (my == vact - 1);
      for (int m = 0; m < 3; m++) begin
        if (m != 0 || (mx >= K - 1 && my >= K - 1)) begin
          exp_en[m]  = 1'b1;
          exp_win[m] = model_win(m, mx, my);
          exp_cx[m]  = CW'(mx);
          exp_cy[m]  = CW'(my);
        end
      end
      mx++;
      if (mx == hact) begin
        mx = 0;
        my++;
        if (my == vact) my = 0;
      end
    end
  endtask

  task automatic test_reset();
    h_active = CW'(8);
    v_active = CW'(6);
    tick(1'b1, 16'h0abc, 1'b1, 1'b1);
    tick(1'b0, 16'h0000, 1'b0, 1'b1);
    for (int m = 0; m < 3; m++) begin
      checks++;
      if ({en[m], endf[m], cx[m], cy[m], win[m]} !== {(2+2*CW+WW){1'b0}}) begin
        errors++;
        $display("FAIL reset_b%0d: en=%b end=%b cur=(%0d,%0d) win=%h, required all zero",
                 m, en[m], endf[m], cx[m], cy[m], win[m]);
      end
    end
  endtask

  task automatic test_frame_basic();
    int n_en[3];
    int n_end;
    logic [K*DW-1:0] row_top, row_bot;
    n_en    = '{default: 0};
    n_end   = 0;
    row_top = {16'h0002, 16'h0001, 16'h0000, 16'h0000, 16'h0000};
    row_bot = {16'h0012, 16'h0011, 16'h0010, 16'h0010, 16'h0010};
    h_active = CW'(8);
    v_active = CW'(6);
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 8; x++) begin
        tick(1'b1, DW'(y*16 + x), (x == 0 && y == 0), 1'b0);
        for (int m = 0; m < 3; m++) begin
          checks++;
          if ({en[m], endf[m], cx[m], cy[m], win[m]} !==
              {exp_en[m], exp_end, exp_cx[m], exp_cy[m], exp_win[m]}) begin
            errors++;
            $display("FAIL basic_b%0d at (%0d,%0d): en=%b end=%b cur=(%0d,%0d) win=%h; required en=%b end=%b cur=(%0d,%0d) win=%h",
                     m, x, y, en[m], endf[m], cx[m], cy[m], win[m],
                     exp_en[m], exp_end, exp_cx[m], exp_cy[m], exp_win[m]);
          end
          if (en[m]) n_en[m]++;
        end
        if (endf[0]) n_end++;
        if (x == 4 && y == 4) begin
          checks++;
          if (n_en[0] != 1 || cx[0] !== 12'd4 || cy[0] !== 12'd4 ||
              elem(win[0], 0, 0) !== 16'h0000 || elem(win[0], 4, 4) !== 16'h0044 ||
              elem(win[0], 2, 2) !== 16'h0022) begin
            errors++;
            $display("FAIL first_window: pulses=%0d cur=(%0d,%0d) w00=%h w44=%h w22=%h; required 1 (4,4) 0000 0044 0022",
                     n_en[0], cx[0], cy[0], elem(win[0], 0, 0), elem(win[0], 4, 4), elem(win[0], 2, 2));
          end
        end
        if (x == 1 && y == 0) begin
          checks++;
          if (elem(win[1], 4, 3) !== 16'h0000 || elem(win[1], 4, 4) !== 16'h0001 ||
              win[1][4*K*DW-1:0] !== {(4*K*DW){1'b0}}) begin
            errors++;
            $display("FAIL zpad_1_0: w43=%h w44=%h rows0_3=%h; required 0000 0001 and zero rows",
                     elem(win[1], 4, 3), elem(win[1], 4, 4), win[1][4*K*DW-1:0]);
          end
        end
        if (x == 0 && y == 5) begin
          checks++;
          if (win[1][4*K*DW +: 4*DW] !== {(4*DW){1'b0}} || elem(win[1], 0, 4) !== 16'h0010) begin
            errors++;
            $display("FAIL zpad_0_5: row4_c0_3=%h w04=%h; required 0 and 0010",
                     win[1][4*K*DW +: 4*DW], elem(win[1], 0, 4));
          end
        end
        if (x == 0 && y == 0) begin
          checks++;
          if (win[2] !== {WW{1'b0}}) begin
            errors++;
            $display("FAIL repl_0_0: win=%h, required all zero", win[2]);
          end
        end
        if (x == 2 && y == 1) begin
          checks++;
          if (win[2] !== {row_bot, row_top, row_top, row_top, row_top}) begin
            errors++;
            $display("FAIL repl_2_1: win=%h, required %h", win[2],
                     {row_bot, row_top, row_top, row_top, row_top});
          end
        end
        if (x == 7 && y == 5) begin
          checks++;
          if (endf[0] !== 1'b1 || endf[1] !== 1'b1 || endf[2] !== 1'b1) begin
            errors++;
            $display("FAIL endflag_0x57: got %b%b%b, required 111", endf[0], endf[1], endf[2]);
          end
        end
      end
    end
    checks++;
    if (n_en[0] != 8 || n_en[1] != 48 || n_en[2] != 48 || n_end != 1) begin
      errors++;
      $display("FAIL basic_counts: outEn=%0d/%0d/%0d endFlag=%0d; required 8/48/48 and 1",
               n_en[0], n_en[1], n_en[2], n_end);
    end
  endtask

  task automatic test_gaps();
    logic [DW-1:0] pix [48];
    logic [WW-1:0] q_ref[$];
    logic [WW-1:0] q_gap[$];
    int i;
    bit go;
    h_active = CW'(8);
    v_active = CW'(6);
    for (int j = 0; j < 48; j++) pix[j] = DW'($urandom);
    for (int pass = 0; pass < 2; pass++) begin
      i = 0;
      while (i < 48) begin
        go = (pass == 0) || ($urandom_range(1, 0) == 1);
        if (go) tick(1'b1, pix[i], (i == 0), 1'b0);
        else    tick(1'b0, DW'($urandom), 1'($urandom_range(1, 0)), 1'b0);
        for (int m = 0; m < 3; m++) begin
          checks++;
          if ({en[m], endf[m], cx[m], cy[m], win[m]} !==
              {exp_en[m], exp_end, exp_cx[m], exp_cy[m], exp_win[m]}) begin
            errors++;
            $display("FAIL gaps_b%0d pass%0d px%0d: en=%b end=%b cur=(%0d,%0d) win=%h; required en=%b end=%b cur=(%0d,%0d) win=%h",
                     m, pass, i, en[m], endf[m], cx[m], cy[m], win[m],
                     exp_en[m], exp_end, exp_cx[m], exp_cy[m], exp_win[m]);
          end
        end
        if (en[0]) begin
          if (pass == 0) q_ref.push_back(win[0]);
          else           q_gap.push_back(win[0]);
        end
        if (go) i++;
      end
    end
    checks++;
    if (q_ref.size() != 8 || q_gap.size() != 8) begin
      errors++;
      $display("FAIL gaps_count: gap-free=%0d gapped=%0d, required 8 each", q_ref.size(), q_gap.size());
    end else begin
      for (int j = 0; j < 8; j++) begin
        checks++;
        if (q_gap[j] !== q_ref[j]) begin
          errors++;
          $display("FAIL gaps_seq[%0d]: gapped %h, gap-free %h", j, q_gap[j], q_ref[j]);
        end
      end
    end
  endtask

  task automatic test_sof_abort();
    int n0, n_end;
    n0 = 0;
    n_end = 0;
    h_active = CW'(8);
    v_active = CW'(6);
    // 19 pixels reach (2,2); the 20th (counter position (3,2)) carries sof
    for (int i = 0; i < 19 + 48; i++) begin
      if (i < 19) tick(1'b1, DW'((i / 8) * 16 + i % 8), (i == 0), 1'b0);
      else        tick(1'b1, DW'($urandom), (i == 19), 1'b0);
      for (int m = 0; m < 3; m++) begin
        checks++;
        if ({en[m], endf[m], cx[m], cy[m], win[m]} !==
            {exp_en[m], exp_end, exp_cx[m], exp_cy[m], exp_win[m]}) begin
          errors++;
          $display("FAIL sof_abort_b%0d step%0d: en=%b end=%b cur=(%0d,%0d) win=%h; required en=%b end=%b cur=(%0d,%0d) win=%h",
                   m, i, en[m], endf[m], cx[m], cy[m], win[m],
                   exp_en[m], exp_end, exp_cx[m], exp_cy[m], exp_win[m]);
        end
      end
      if (en[0]) n0++;
      if (endf[0]) n_end++;
    end
    checks++;
    if (n0 != 8 || n_end != 1 || endf[0] !== 1'b1) begin
      errors++;
      $display("FAIL sof_abort_counts: windows=%0d endFlags=%0d last_end=%b; required 8, 1, 1",
               n0, n_end, endf[0]);
    end
  endtask

  task automatic test_rst_mid();
    int n0, n_end;
    n0 = 0;
    n_end = 0;
    h_active = CW'(8);
    v_active = CW'(6);
    for (int i = 0; i < 20 + 2 + 48; i++) begin
      if (i < 20)      tick(1'b1, DW'($urandom), (i == 0), 1'b0);
      else if (i < 22) tick(1'b1, DW'($urandom), (i == 20), 1'b1);
      else             tick(1'b1, DW'(((i - 22) / 8) * 16 + (i - 22) % 8), 1'b0, 1'b0);
      // the geometry input changes right after the new origin is accepted
      if (i == 22) h_active = CW'(6);
      for (int m = 0; m < 3; m++) begin
        checks++;
        if ({en[m], endf[m], cx[m], cy[m], win[m]} !==
            {exp_en[m], exp_end, exp_cx[m], exp_cy[m], exp_win[m]}) begin
          errors++;
          $display("FAIL rst_mid_b%0d step%0d: en=%b end=%b cur=(%0d,%0d) win=%h; required en=%b end=%b cur=(%0d,%0d) win=%h",
                   m, i, en[m], endf[m], cx[m], cy[m], win[m],
                   exp_en[m], exp_end, exp_cx[m], exp_cy[m], exp_win[m]);
        end
      end
      if (i == 21) begin
        checks++;
        if ({en[1], endf[1], cx[1], cy[1], win[1]} !== {(2+2*CW+WW){1'b0}}) begin
          errors++;
          $display("FAIL rst_mid_zero: en=%b end=%b cur=(%0d,%0d) win=%h, required all zero",
                   en[1], endf[1], cx[1], cy[1], win[1]);
        end
      end
      if (i >= 22) begin
        if (en[0]) n0++;
        if (endf[0]) n_end++;
      end
    end
    checks++;
    if (n0 != 8 || n_end != 1 || endf[0] !== 1'b1 || cx[0] !== 12'd7 || cy[0] !== 12'd5) begin
      errors++;
      $display("FAIL rst_mid_counts: windows=%0d endFlags=%0d last_end=%b cur=(%0d,%0d); required 8, 1, 1, (7,5)",
               n0, n_end, endf[0], cx[0], cy[0]);
    end
    h_active = CW'(8);
  endtask

  task automatic test_random_geometry();
    int hw, vh, n;
    bit go;
    for (int f = 0; f < 3; f++) begin
      hw = $urandom_range(12, 5);
      vh = $urandom_range(8, 5);
      h_active = CW'(hw);
      v_active = CW'(vh);
      n = 0;
      while (n < hw * vh) begin
        go = ($urandom_range(9, 0) < 7);
        if (go) tick(1'b1, DW'($urandom), (n == 0), 1'b0);
        else    tick(1'b0, DW'($urandom), 1'b0, 1'b0);
        for (int m = 0; m < 3; m++) begin
          checks++;
          if ({en[m], endf[m], cx[m], cy[m], win[m]} !==
              {exp_en[m], exp_end, exp_cx[m], exp_cy[m], exp_win[m]}) begin
            errors++;
            $display("FAIL rand_geom_b%0d %0dx%0d px%0d: en=%b end=%b cur=(%0d,%0d) win=%h; required en=%b end=%b cur=(%0d,%0d) win=%h",
                     m, hw, vh, n, en[m], endf[m], cx[m], cy[m], win[m],
                     exp_en[m], exp_end, exp_cx[m], exp_cy[m], exp_win[m]);
          end
        end
        if (go) n++;
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    dataEn   = 1'b0;
    dataIn   = {DW{1'b0}};
    sof      = 1'b0;
    h_active = CW'(8);
    v_active = CW'(6);
    mx = 0;
    my = 0;
    hact = 8;
    vact = 6;
    test_reset();
    test_frame_basic();
    test_gaps();
    test_sof_abort();
    test_rst_mid();
    test_random_geometry();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
